// File: rtl/ifetch_prefetch_q_if.sv
// ifetch_prefetch_q_if -- fetch-unit bus bundle.
//   redirect_valid/redirect_pc : absolute redirect from execute
//   imem_en/imem_addr/imem_rdata : synchronous ROM port, 1-cycle read latency
//   inst_valid/inst/inst_pc/inst_ready : prefetch queue head to decode
// slave  = the fetch unit, master = its environment (execute, ROM, decode).
interface ifetch_prefetch_q_if #(
  parameter int ADDR_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_en;
  logic [ADDR_W-3:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport slave (
    input  redirect_valid, redirect_pc, imem_rdata, inst_ready,
    output imem_en, imem_addr, inst_valid, inst, inst_pc
  );

  modport master (
    output redirect_valid, redirect_pc, imem_rdata, inst_ready,
    input  imem_en, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/ifetch_prefetch_q.sv
// ifetch_prefetch_q -- instruction fetch with prefetch queue.
// Issues word reads to a 1-cycle-latency ROM, buffers {inst, pc} pairs in a
// QDEPTH-entry queue and hands the head to decode with valid/ready.
// A redirect flushes the queue and drops any in-flight read.
// Ports:
//   clk  : clock, posedge
//   rst  : synchronous reset, active low
//   bus  : ifetch_prefetch_q_if.slave (redirect, ROM port, decode handshake)
//   perf_fetch_cnt/perf_flush_cnt/perf_stall_cnt : only with IFETCH_PERF_EN
// Optional macro: IFETCH_PERF_EN adds the performance counters.
module ifetch_prefetch_q #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ifetch_prefetch_q_if.slave   bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_flush_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] RST_PC = {RESET_PC[ADDR_W-1:2], 2'b00};

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic              infl_q, infl_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       mem_inst_q [QDEPTH];
  logic [ADDR_W-1:0] mem_pc_q   [QDEPTH];

  logic [CW-1:0] used;
  logic          issue, push, pop, vld;

  // Credits: queued entries plus the read still in flight. Never issuing past
  // QDEPTH is what lets a return be pushed unconditionally.
  assign used  = count_q + {{(CW-1){1'b0}}, infl_q};
  assign issue = rst & ~bus.redirect_valid & (used < CW'(QDEPTH));
  assign push  = rst & infl_q & ~bus.redirect_valid;
  assign vld   = rst & (count_q != '0);
  assign pop   = vld & bus.inst_ready;

  assign bus.imem_en    = issue;
  assign bus.imem_addr  = fetch_pc_q[ADDR_W-1:2];
  assign bus.inst_valid = vld;
  assign bus.inst       = mem_inst_q[rd_ptr_q];
  assign bus.inst_pc    = mem_pc_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    infl_pc_d  = infl_pc_q;
    infl_d     = infl_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (!rst) begin
      fetch_pc_d = RST_PC;
      infl_d     = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over push/pop; whatever was at the head is gone anyway.
      fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      infl_d     = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      infl_d = issue;
      if (issue) begin
        infl_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    fetch_pc_q <= fetch_pc_d;
    infl_pc_q  <= infl_pc_d;
    infl_q     <= infl_d;
    rd_ptr_q   <= rd_ptr_d;
    wr_ptr_q   <= wr_ptr_d;
    count_q    <= count_d;
  end

  // Storage is not reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst_q[wr_ptr_q] <= bus.imem_rdata;
      mem_pc_q[wr_ptr_q]   <= infl_pc_q;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bus.redirect_valid && ((count_q != '0) || infl_q))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (!vld) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_prefetch_q.sv
// tb_ifetch_prefetch_q -- randomized + directed bench against a queue-based
// reference model of the fetch unit. A second ADDR_W=8 instance covers PC wrap.
module tb_ifetch_prefetch_q;
  localparam int          QDEPTH = 4;
  localparam logic [31:0] RPC    = 32'h100;
  localparam logic [31:0] KEY    = 32'hC0DE_0000;

  logic clk = 1'b0;
  logic rst, rst8;
  always #5 clk = ~clk;

  ifetch_prefetch_q_if #(.ADDR_W(32)) bus ();
  ifetch_prefetch_q_if #(.ADDR_W(8))  bus8 ();

`ifdef IFETCH_PERF_EN
  logic [31:0] pf_fetch, pf_flush, pf_stall, p8_a, p8_b, p8_c;
`endif

  ifetch_prefetch_q #(.ADDR_W(32), .RESET_PC(RPC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(pf_fetch), .perf_flush_cnt(pf_flush), .perf_stall_cnt(pf_stall)
`endif
  );

  ifetch_prefetch_q #(.ADDR_W(8), .RESET_PC(8'hF8), .QDEPTH(QDEPTH)) dut8 (
    .clk(clk), .rst(rst8), .bus(bus8)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(p8_a), .perf_flush_cnt(p8_b), .perf_stall_cnt(p8_c)
`endif
  );

  // ROMs: 1-cycle latency, content is a known function of the word address.
  always_ff @(posedge clk) if (bus.imem_en)  bus.imem_rdata  <= KEY ^ {2'b00, bus.imem_addr};
  always_ff @(posedge clk) if (bus8.imem_en) bus8.imem_rdata <= KEY ^ {26'd0, bus8.imem_addr};

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: PCs waiting for decode, the read in flight, next fetch PC.
  logic [31:0] mq[$];
  bit          m_infl;
  logic [31:0] m_ipc, m_fpc;
  logic [31:0] m_fetch, m_flush, m_stall;

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit exp_en, exp_vld;
    int sz;
    rst = r; bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.inst_ready = rdy;
    #2;
    sz      = mq.size();
    exp_en  = r && !rv && (sz + int'(m_infl) < QDEPTH);
    exp_vld = r && (sz > 0);
    chk("imem_en", 64'(bus.imem_en), 64'(exp_en));
    if (exp_en) chk("imem_addr", 64'(bus.imem_addr), 64'(m_fpc >> 2));
    chk("inst_valid", 64'(bus.inst_valid), 64'(exp_vld));
    if (exp_vld) begin
      chk("inst_pc", 64'(bus.inst_pc), 64'(mq[0]));
      chk("inst", 64'(bus.inst), 64'(KEY ^ (mq[0] >> 2)));
    end
`ifdef IFETCH_PERF_EN
    chk("perf_fetch", 64'(pf_fetch), 64'(m_fetch));
    chk("perf_flush", 64'(pf_flush), 64'(m_flush));
    chk("perf_stall", 64'(pf_stall), 64'(m_stall));
`endif
    @(posedge clk);
    if (!r) begin
      mq.delete(); m_infl = 0; m_fpc = RPC & ~32'd3;
      m_fetch = 0; m_flush = 0; m_stall = 0;
    end else begin
      if (exp_en)   m_fetch++;
      if (!exp_vld) m_stall++;
      if (rv) begin
        if (sz > 0 || m_infl) m_flush++;
        mq.delete(); m_infl = 0; m_fpc = rpc & ~32'd3;
      end else begin
        if (exp_vld && rdy) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_ipc);
        m_infl = exp_en;
        if (exp_en) begin m_ipc = m_fpc; m_fpc = m_fpc + 32'd4; end
      end
    end
    #1;
  endtask

  initial begin
    logic [7:0] exp8 [4];
    int n8;
    exp8 = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    rst = 0; rst8 = 0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.inst_ready = 0;
    bus8.redirect_valid = 0; bus8.redirect_pc = '0; bus8.inst_ready = 1;
    mq.delete(); m_infl = 0; m_ipc = '0; m_fpc = RPC;
    m_fetch = 0; m_flush = 0; m_stall = 0;
    @(posedge clk); #1;

    // Reset held, then streaming with decode always ready.
    repeat (3)  step(0, 0, '0, 1);
    repeat (12) step(1, 0, '0, 1);

    // Backpressure: fill to QDEPTH, issue stops, then drain in order.
    repeat (10) step(1, 0, '0, 0);
    repeat (10) step(1, 0, '0, 1);

    // Build up 3 queued + 1 in flight, then redirect to an unaligned target.
    step(1, 1, 32'h100, 0);
    for (int i = 0; i < 12 && !(mq.size() == 3 && m_infl); i++) step(1, 0, '0, 0);
    step(1, 1, 32'h203, 1);
    repeat (6) step(1, 0, '0, 1);

    // Back-to-back redirects: last target wins.
    step(1, 1, 32'h10, 1);
    step(1, 1, 32'h20, 1);
    step(1, 1, 32'h30, 1);
    repeat (6) step(1, 0, '0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit r, rv, rdy;
      r   = ($urandom_range(0, 99) >= 2);
      rv  = ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 60);
      step(r, rv, $urandom, rdy);
    end

    // Mid-stream reset with a full queue.
    repeat (8) step(1, 0, '0, 0);
    step(0, 0, '0, 0);
    repeat (6) step(1, 0, '0, 1);

    // ADDR_W=8 wrap: inst_pc F8, FC, 00, 04.
    rst8 = 1;
    n8 = 0;
    for (int i = 0; i < 12 && n8 < 4; i++) begin
      @(posedge clk); #3;
      if (bus8.inst_valid) begin
        chk("wrap_pc", 64'(bus8.inst_pc), 64'(exp8[n8]));
        n8++;
      end
    end
    chk("wrap_count", 64'(n8), 64'd4);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
